// File: rtl/fa_response_checker.sv
// Full-adder response checker: compares (a,b,cin) -> (sum,co) against the golden adder,
// counts mismatches, records the first failing vector index, and compacts responses in a MISR.
module fa_response_checker #(
  parameter int                 NUM_VEC  = 8,
  parameter int                 CNT_W    = 16,
  parameter int                 SIG_W    = 16,
  parameter logic [SIG_W-1:0]   SIG_POLY = 16'hB400,
  parameter logic [SIG_W-1:0]   SIG_SEED = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [SIG_W-1:0] signature
);

  // state | meaning
  // IDLE  | after reset, waiting for first start
  // RUN   | accepting vectors until NUM_VEC have been taken
  // DONE  | results frozen until next start
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic [SIG_W-1:0] sig_q, sig_d;

  logic accept, clear, last_acc;
  logic exp_sum, exp_co, mismatch;

  assign accept   = in_valid & in_ready;
  assign clear    = start & (state_q != S_RUN);
  assign last_acc = accept & (vec_cnt_q == CNT_W'(NUM_VEC - 1));

  assign exp_sum  = a ^ b ^ cin;
  assign exp_co   = (a & b) | (a & cin) | (b & cin);
  assign mismatch = (sum != exp_sum) | (co != exp_co);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_RUN;
      S_RUN:   if (last_acc) state_d = S_DONE;
      S_DONE:  if (start)    state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_RUN);
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    pass     = (state_q == S_DONE) && (err_cnt_q == '0);
  end

  // Bubbles leave counters and the MISR untouched; only clear or accept moves them.
  always_comb begin
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    sig_d     = sig_q;
    if (clear) begin
      vec_cnt_d = '0;
      err_cnt_d = '0;
      first_d   = '1;
      sig_d     = SIG_SEED;
    end else if (accept) begin
      vec_cnt_d = vec_cnt_q + 1'b1;
      if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        if (first_q == '1)   first_d   = vec_cnt_q;
      end
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
            ^ {{(SIG_W-2){1'b0}}, sum, co};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      first_q   <= '1;
      sig_q     <= SIG_SEED;
    end else begin
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
      sig_q     <= sig_d;
    end
  end

  assign vec_cnt       = vec_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_q;
  assign signature     = sig_q;

endmodule

// File: tb/tb_fa_response_checker.sv
// Scoreboard bench for fa_response_checker: a reference model predicts results per accepted
// vector, and a monitor compares them one cycle after each accept.
module tb_fa_response_checker;

  localparam int          NUM_VEC = 8;
  localparam logic [15:0] POLY    = 16'hB400;
  localparam logic [15:0] SEED    = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        a = 1'b0, b = 1'b0, cin = 1'b0, sum = 1'b0, co = 1'b0;
  logic        busy, done, pass;
  logic [15:0] vec_cnt, err_cnt, first_err_idx, signature;

  int checks = 0;
  int errors = 0;

  fa_response_checker #(
    .NUM_VEC(NUM_VEC), .CNT_W(16), .SIG_W(16), .SIG_POLY(POLY), .SIG_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sum(sum), .co(co),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .signature(signature)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vec;
    logic [15:0] err;
    logic [15:0] first;
    logic [15:0] sig;
    bit          last;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  int          m_vec, m_err;
  logic [15:0] m_first, m_sig;
  bit          m_running;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vec = 0; m_err = 0; m_first = 16'hFFFF; m_sig = SEED; m_running = 0;
  endtask

  task automatic model_accept(input int va, vb, vc, vs, vco);
    int   total;
    bit   bad;
    exp_t e;
    total = va + vb + vc;
    bad   = (vs != total % 2) || (vco != total / 2);
    if (bad) begin
      if (m_err < 16'hFFFF) m_err++;
      if (m_first == 16'hFFFF) m_first = 16'(m_vec);
    end
    m_vec++;
    m_sig = 16'((m_sig * 2) % 65536) ^ (m_sig >= 16'h8000 ? POLY : 16'h0) ^ 16'(vs * 2 + vco);
    e.vec = 16'(m_vec); e.err = 16'(m_err); e.first = m_first; e.sig = m_sig;
    e.last = (m_vec == NUM_VEC);
    if (e.last) m_running = 0;
    exp_q.push_back(e);
  endtask

  // monitor: an accept at a posedge is checked 1 time unit later
  always @(posedge clk) begin
    bit   fire;
    exp_t e;
    fire = rst_n && in_valid && in_ready;
    #1;
    if (fire) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("vec_cnt", vec_cnt, e.vec);
        chk("err_cnt", err_cnt, e.err);
        chk("first_err_idx", first_err_idx, e.first);
        chk("signature", signature, e.sig);
        chk("done", done, e.last);
        chk("busy", busy, !e.last);
        chk("in_ready", in_ready, !e.last);
        chk("pass", pass, e.last && (e.err == 0));
      end
    end
  end

  // called at a negedge; returns at the negedge following the accept
  task automatic send(input int va, vb, vc, vs, vco);
    int guard;
    a = 1'(va); b = 1'(vb); cin = 1'(vc); sum = 1'(vs); co = 1'(vco);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      model_accept(va, vb, vc, vs, vco);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    if (!m_running) begin
      model_reset();
      m_running = 1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_good(input int idx, input bit flip_co);
    int va, vb, vc, t;
    va = (idx >> 2) & 1; vb = (idx >> 1) & 1; vc = idx & 1;
    t  = va + vb + vc;
    send(va, vb, vc, t % 2, (t / 2) ^ int'(flip_co));
  endtask

  task automatic send_rand();
    int va, vb, vc, t, vs, vco, f;
    va = int'($urandom_range(0, 1)); vb = int'($urandom_range(0, 1)); vc = int'($urandom_range(0, 1));
    t  = va + vb + vc;
    vs = t % 2; vco = t / 2;
    f  = int'($urandom_range(0, 7));
    if (f == 1) vs ^= 1;
    if (f == 2) vco ^= 1;
    if (f == 3) begin vs ^= 1; vco ^= 1; end
    send(va, vb, vc, vs, vco);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_vec_cnt"}, vec_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_first"}, first_err_idx, 16'hFFFF);
    chk({tag, "_sig"}, signature, SEED);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // 1: reset held with in_valid high, then idle with in_valid high
    in_valid = 1'b1; a = 1'b1; sum = 1'b1;
    gap(3);
    chk_reset_vals("t1_rst");
    rst_n = 1'b1;
    gap(3);
    chk_reset_vals("t1_idle");
    in_valid = 1'b0;

    // 2: directed signature vectors, then complete the run
    pulse_start();
    chk("t2_busy", busy, 1);
    send(0, 1, 0, 1, 0);
    chk("t2_sig0", signature, 16'h0002);
    send(1, 0, 1, 0, 1);
    chk("t2_sig1", signature, 16'h0005);
    chk("t2_err", err_cnt, 0);
    chk("t2_vec", vec_cnt, 2);
    for (int i = 0; i < NUM_VEC - 2; i++) send_rand();

    // 3: exhaustive correct run with gaps
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_good(i, 0);
      gap(int'($urandom_range(0, 2)));
    end
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 1);
    chk("t3_err", err_cnt, 0);
    chk("t3_first", first_err_idx, 16'hFFFF);
    chk("t3_vec", vec_cnt, 8);
    chk("t3_busy", busy, 0);

    // in_valid in DONE must be ignored
    in_valid = 1'b1;
    gap(3);
    in_valid = 1'b0;
    chk("t3_hold_vec", vec_cnt, 8);

    // 4: co flipped on vectors 3 and 6
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_good(i, (i == 3) || (i == 6));
      gap(int'($urandom_range(0, 1)));
    end
    chk("t4_err", err_cnt, 2);
    chk("t4_first", first_err_idx, 3);
    chk("t4_pass", pass, 0);
    chk("t4_done", done, 1);

    // 5: start in RUN ignored, start in DONE clears
    pulse_start();
    for (int i = 0; i < 4; i++) send_rand();
    pulse_start();
    chk("t5_vec_mid", vec_cnt, 4);
    for (int i = 0; i < 4; i++) send_rand();
    chk("t5_vec", vec_cnt, 8);
    chk("t5_done", done, 1);
    pulse_start();
    chk("t5_clr_vec", vec_cnt, 0);
    chk("t5_clr_err", err_cnt, 0);
    chk("t5_clr_first", first_err_idx, 16'hFFFF);
    chk("t5_clr_sig", signature, SEED);
    chk("t5_clr_busy", busy, 1);
    chk("t5_clr_done", done, 0);

    // 6: async reset mid-run, then a clean run
    for (int i = 0; i < 5; i++) send_rand();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    gap(1);
    chk_reset_vals("t6_after");
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      for (int i = 0; i < NUM_VEC; i++) begin
        send_rand();
        gap(int'($urandom_range(0, 2)));
      end
      chk("t6_done", done, 1);
    end

    gap(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
